// File: rtl/microondas_pkg.sv
// Shared constants and types for the multiplexed 4-digit seven-segment display.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package microondas_pkg;

  localparam int SCAN_DIV_DEFAULT   = 50000;
  localparam int BLINK_HALF_DEFAULT = 250;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Index 0 drives an[0] (sec_units); index 3 drives an[3] (min_tens).
  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} dig_idx_t;

  function automatic dig_idx_t next_dig(input dig_idx_t d);
    case (d)
      DIG0:    return DIG1;
      DIG1:    return DIG2;
      DIG2:    return DIG3;
      default: return DIG0;
    endcase
  endfunction

endpackage

// File: rtl/bcd7seg.sv
// Combinational BCD to active-low seven-segment lookup; values above 9 show a dash.
module bcd7seg
  import microondas_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_scan_decoder.sv
// Time-multiplexed 4-digit display driver: shadow digit capture, scan prescaler,
// digit index FSM, leading-zero blanking, blinking and colon decimal point.
module display_scan_decoder
  import microondas_pkg::*;
#(
  parameter int SCAN_DIV   = SCAN_DIV_DEFAULT,
  parameter int BLINK_HALF = BLINK_HALF_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] min_tens,
  input  logic [3:0] min_units,
  input  logic [3:0] sec_tens,
  input  logic [3:0] sec_units,
  input  logic       blank_lz,
  input  logic       blink_en,
  input  logic       colon_en,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       err
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = $clog2(BLINK_HALF + 1);

  logic [3:0]    digit_in   [4];
  logic [3:0]    shadow_reg [4];
  logic [6:0]    dec        [4];
  logic [3:0]    digit_err;

  logic [PW-1:0] presc_reg;
  logic          tick;
  dig_idx_t      idx_reg;
  logic [BW-1:0] blink_cnt_reg;
  logic          phase_on_reg;
  logic          blink_prev_reg;

  logic [6:0]    seg_next;
  logic [3:0]    an_next;
  logic          dp_next;

  assign digit_in[0] = sec_units;
  assign digit_in[1] = sec_tens;
  assign digit_in[2] = min_units;
  assign digit_in[3] = min_tens;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst)       shadow_reg[i] <= 4'd0;
      else if (load) shadow_reg[i] <= digit_in[i];
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      bcd7seg u_dec (
        .bcd (shadow_reg[gi]),
        .seg (dec[gi])
      );
      assign digit_err[gi] = (shadow_reg[gi] > 4'd9);
    end
  endgenerate

  assign err = |digit_err;

  assign tick = (presc_reg == PW'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) presc_reg <= '0;
    else             presc_reg <= presc_reg + PW'(1);
  end

  // Output decode works from the pre-edge index and shadow, giving one cycle of latency.
  always_comb begin
    seg_next = dec[idx_reg];
    if (blank_lz) begin
      if (idx_reg == DIG3 && shadow_reg[3] == 4'd0)
        seg_next = SEG_BLANK;
      if (idx_reg == DIG2 && shadow_reg[3] == 4'd0 && shadow_reg[2] == 4'd0)
        seg_next = SEG_BLANK;
    end
    an_next = phase_on_reg ? ~(4'b0001 << idx_reg) : 4'b1111;
    dp_next = ~(idx_reg == DIG2 && colon_en && phase_on_reg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg        <= DIG0;
      blink_cnt_reg  <= '0;
      phase_on_reg   <= 1'b1;
      blink_prev_reg <= 1'b0;
      seg            <= SEG_BLANK;
      an             <= 4'b1111;
      dp             <= 1'b1;
    end else begin
      blink_prev_reg <= blink_en;
      seg            <= seg_next;
      an             <= an_next;
      dp             <= dp_next;
      if (tick)
        idx_reg <= next_dig(idx_reg);
      // A fresh enable (or no enable) restarts the blink cycle in the on phase.
      if (!blink_en || !blink_prev_reg) begin
        blink_cnt_reg <= '0;
        phase_on_reg  <= 1'b1;
      end else if (tick) begin
        if (blink_cnt_reg == BW'(BLINK_HALF - 1)) begin
          blink_cnt_reg <= '0;
          phase_on_reg  <= ~phase_on_reg;
        end else begin
          blink_cnt_reg <= blink_cnt_reg + BW'(1);
        end
      end
    end
  end

endmodule

// File: doc/display_scan_decoder.md
DISPLAY_SCAN_DECODER -- requirements
Module: display_scan_decoder

Interface
REQ-001 Parameter SCAN_DIV, 50000: clk cycles per digit slot; legal range is 2 or more.
REQ-002 Parameter BLINK_HALF, 250: scan ticks per blink half-period; legal range is 1 or more.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 load  input  1  capture strobe for the digit inputs.
REQ-006 min_tens, min_units, sec_tens, sec_units  input  4 each  BCD digits from the timer/encoder path.
REQ-007 blank_lz  input  1  enables leading-zero blanking.
REQ-008 blink_en  input  1  enables display blinking ("done" indication).
REQ-009 colon_en  input  1  lights the decimal point on the min_units digit.
REQ-010 seg  output  7  {g,f,e,d,c,b,a}, active-low, registered.
REQ-011 an  output  4  digit anodes, active-low one-hot, registered; an[0]=sec_units, an[3]=min_tens.
REQ-012 dp  output  1  decimal point, active-low, registered.
REQ-013 err  output  1  high while any shadow digit is greater than 9.

Function
REQ-014 When load=1 in cycle n, all four digits SHALL be copied to shadow registers, visible from cycle n+1; all other cycles hold the shadow values.
REQ-015 The prescaler SHALL count 0..SCAN_DIV-1 and wrap; a tick SHALL occur in the cycle where count = SCAN_DIV-1.
REQ-016 The digit index state machine SHALL have states DIG0..DIG3 and advance DIG0->DIG1->DIG2->DIG3->DIG0 on each tick only.
REQ-017 seg, an and dp SHALL reflect the current index and shadow values with a latency of exactly one cycle.
REQ-018 Decode values SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-019 A digit value of 10 to 15 SHALL display dash 0111111, and err SHALL be 1 from the cycle after the shadow is loaded until a valid load.
REQ-020 When blank_lz=1, the min_tens digit SHALL show blank (1111111) if it is 0.
REQ-021 When blank_lz=1, the min_units digit SHALL show blank if both min_tens and min_units are 0.
REQ-022 The seconds digits SHALL never be blanked by blank_lz.
REQ-023 The blink phase SHALL toggle every BLINK_HALF ticks while blink_en=1; during the off phase, an SHALL be 1111.
REQ-024 On a 0->1 edge of blink_en, the blink counter SHALL clear and the phase SHALL start in the on phase; while blink_en=0, the phase SHALL be held on.
REQ-025 dp SHALL be 0 only when the index is DIG2, colon_en=1 and the display is in the on phase; otherwise dp SHALL be 1.
REQ-026 If load and a tick occur in the same cycle, both SHALL take effect, and the new index SHALL display the new shadow value.
REQ-027 A load SHALL NOT disturb the prescaler, the index or the blink phase.

Reset
REQ-028 While rst=1, the block SHALL set: shadow digits = 0, prescaler = 0, index = DIG0, blink counter = 0, phase = on, seg=1111111, an=1111, dp=1, err=0.
REQ-029 Reset SHALL override load and tick in the same cycle.
REQ-030 Reset asserted mid-scan or mid-blink SHALL restart scanning at DIG0 with a full SCAN_DIV slot after release.

Structure
REQ-031 Package microondas_pkg SHALL hold: the segment constants (digits 0-9, dash, blank), the digit index typedef (DIG0..DIG3), and the default SCAN_DIV and BLINK_HALF.
REQ-032 The combinational BCD-to-segment lookup SHALL be the sub-module bcd7seg (4-bit in, 7-bit out, dash for values above 9).

Verification (SCAN_DIV=4, BLINK_HALF=2)
REQ-033 Reset, then load 1,2,3,4 (min_tens..sec_units) -> an cycles 1110,1101,1011,0111 with seg 0011001, 0110000, 0100100, 1111001, each held for 4 cycles.
REQ-034 blank_lz=1, load 0,0,0,5 -> min digits show 1111111, sec_tens shows 1000000, sec_units shows 0010010.
REQ-035 Load sec_units=12 -> err=1 the next cycle and the DIG0 slot shows 0111111; then load 9 -> err=0 and the slot shows 0010000.
REQ-036 blink_en 0->1 -> anodes active for 2 ticks (8 cycles), then an=1111 for 8 cycles, repeating; colon_en=1 gives dp=0 only in DIG2 on-phase slots.
REQ-037 Load coincident with the tick into DIG1 -> the first DIG1 output cycle shows the new sec_tens value; no index slip.
REQ-038 rst pulse during DIG2 -> next cycle seg=1111111, an=1111; after release, DIG0 is active for a full 4-cycle slot.
